// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter
// Purpose  : Shares the single physical-memory line port between the
//            instruction cache and the data cache. Grants one cache at a
//            time, alternates priority on simultaneous requests, and latches
//            address, write data and command at grant so memory sees stable
//            inputs for the whole transaction.
// Ports    : clk, rst_n                       - clock, async active-low reset
//            ipmem_read/address/resp/rdata    - icache line-read side
//            dpmem_read/write/address/wdata,
//            dpmem_resp/rdata                 - dcache read/writeback side
//            pmem_read/write/address/wdata,
//            pmem_resp/rdata                  - memory-side line port
//            protocol_err                     - sticky: dcache read+write at grant
// Revision : 1.0 - initial release
// ============================================================================
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ipmem_read,
    input  logic [ADDR_W-1:0] ipmem_address,
    output logic              ipmem_resp,
    output logic [LINE_W-1:0] ipmem_rdata,

    input  logic              dpmem_read,
    input  logic              dpmem_write,
    input  logic [ADDR_W-1:0] dpmem_address,
    input  logic [LINE_W-1:0] dpmem_wdata,
    output logic              dpmem_resp,
    output logic [LINE_W-1:0] dpmem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,

    output logic              protocol_err
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_gnt_i = 2'd1;
    localparam logic [1:0] c_gnt_d = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_last_d;      // 1: dcache held the most recent grant
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;
    logic              r_protocol_err;

    logic              w_ireq;
    logic              w_dreq;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_finish;

    assign w_ireq   = ipmem_read;
    assign w_dreq   = dpmem_read | dpmem_write;
    assign w_finish = pmem_resp & ((r_state == c_gnt_i) | (r_state == c_gnt_d));

    // ------------------------------------------------------------------------
    // State register plus the registered memory-side command/datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_idle;
            r_last_d       <= 1'b1;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_i) begin
                r_pmem_read    <= 1'b1;
                r_pmem_write   <= 1'b0;
                r_pmem_address <= ipmem_address;
                r_last_d       <= 1'b0;
            end else if (w_grant_d) begin
                // A simultaneous read+write is resolved as a write so that
                // read and write never appear on the memory port together.
                r_pmem_read    <= dpmem_read & ~dpmem_write;
                r_pmem_write   <= dpmem_write;
                r_pmem_address <= dpmem_address;
                r_pmem_wdata   <= dpmem_wdata;
                r_last_d       <= 1'b1;
                if (dpmem_read && dpmem_write) begin
                    r_protocol_err <= 1'b1;
                end
            end else if (w_finish) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic and arbitration
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            c_idle: begin
                // On a tie the side that did not win last time goes first.
                if (w_ireq && (!w_dreq || r_last_d)) begin
                    w_grant_i    = 1'b1;
                    w_next_state = c_gnt_i;
                end else if (w_dreq) begin
                    w_grant_d    = 1'b1;
                    w_next_state = c_gnt_d;
                end
            end
            c_gnt_i, c_gnt_d: begin
                if (pmem_resp) begin
                    w_next_state = c_done;
                end
            end
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: responses are steered combinationally to the owner only
    // ------------------------------------------------------------------------
    always_comb begin
        ipmem_resp = pmem_resp & (r_state == c_gnt_i);
        dpmem_resp = pmem_resp & (r_state == c_gnt_d);
    end

    assign ipmem_rdata  = pmem_rdata;
    assign dpmem_rdata  = pmem_rdata;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_arbiter
// Purpose  : Randomized self-checking bench for pmem_arbiter. A transaction
//            level reference (port owner, turnaround flag, last winner)
//            predicts the memory-side command and the response steering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ipmem_read;
    logic [ADDR_W-1:0] ipmem_address;
    logic              ipmem_resp;
    logic [LINE_W-1:0] ipmem_rdata;
    logic              dpmem_read;
    logic              dpmem_write;
    logic [ADDR_W-1:0] dpmem_address;
    logic [LINE_W-1:0] dpmem_wdata;
    logic              dpmem_resp;
    logic [LINE_W-1:0] dpmem_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;
    logic              protocol_err;

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ipmem_read   (ipmem_read),
        .ipmem_address(ipmem_address),
        .ipmem_resp   (ipmem_resp),
        .ipmem_rdata  (ipmem_rdata),
        .dpmem_read   (dpmem_read),
        .dpmem_write  (dpmem_write),
        .dpmem_address(dpmem_address),
        .dpmem_wdata  (dpmem_wdata),
        .dpmem_resp   (dpmem_resp),
        .dpmem_rdata  (dpmem_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the memory port (0 none, 1 icache, 2 dcache)
    int                m_owner;
    bit                m_turn;     // one mandatory idle cycle after a transaction
    bit                m_last_d;   // dcache won the most recent grant
    bit                m_write;
    bit                m_perr;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;

    // Stimulus bookkeeping
    bit i_pend, d_pend;
    bit rand_en, mem_en;
    int wait_cnt, lat;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_owner  = 0;
        m_turn   = 0;
        m_last_d = 1;
        m_write  = 0;
        m_perr   = 0;
        m_addr   = '0;
        m_wdata  = '0;
    endtask

    // One clock cycle: advance the model on the edge, drive new inputs,
    // then compare outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        if (m_owner != 0) begin
            if (pmem_resp) begin
                if (m_owner == 1) i_pend = 0;
                else              d_pend = 0;
                m_owner = 0;
                m_turn  = 1;
            end
        end else if (m_turn) begin
            m_turn = 0;
        end else begin
            bit ir, dr;
            int winner;
            ir = ipmem_read;
            dr = dpmem_read | dpmem_write;
            if (ir && dr)  winner = m_last_d ? 1 : 2;
            else if (ir)   winner = 1;
            else if (dr)   winner = 2;
            else           winner = 0;
            if (winner == 1) begin
                m_owner  = 1;
                m_write  = 0;
                m_addr   = ipmem_address;
                m_last_d = 0;
            end else if (winner == 2) begin
                m_owner  = 2;
                m_write  = dpmem_write;
                m_addr   = dpmem_address;
                m_wdata  = dpmem_wdata;
                m_last_d = 1;
                if (dpmem_read && dpmem_write) m_perr = 1;
            end
            if (winner != 0) begin
                wait_cnt = 0;
                lat      = $urandom_range(0, 5);
            end
        end

        #1;
        if (rand_en) begin
            if (m_owner == 1) begin
                ipmem_address = $urandom;
                if (i_pend && $urandom_range(0, 9) == 0) i_pend = 0;
            end else if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend        = 1;
                ipmem_address = $urandom & 32'hFFFF_FFE0;
            end
            if (m_owner == 2) begin
                dpmem_address = $urandom;
                dpmem_wdata   = rand_line();
                if (d_pend && $urandom_range(0, 9) == 0) d_pend = 0;
            end else if (!d_pend && $urandom_range(0, 2) == 0) begin
                int k;
                k             = $urandom_range(0, 15);
                d_pend        = 1;
                dpmem_address = $urandom & 32'hFFFF_FFE0;
                dpmem_wdata   = rand_line();
                dpmem_read    = (k < 8) || (k == 15);
                dpmem_write   = (k >= 8);
            end
        end
        ipmem_read = i_pend;
        if (!d_pend) begin
            dpmem_read  = 0;
            dpmem_write = 0;
        end
        if (mem_en) begin
            if (m_owner != 0) begin
                pmem_resp = (wait_cnt >= lat);
                wait_cnt++;
            end else begin
                pmem_resp = ($urandom_range(0, 5) == 0);
            end
        end
        pmem_rdata = rand_line();

        @(negedge clk);
        chk("pmem_read",   pmem_read,  (m_owner == 1) || (m_owner == 2 && !m_write));
        chk("pmem_write",  pmem_write, (m_owner == 2) && m_write);
        chk("ipmem_resp",  ipmem_resp, pmem_resp && (m_owner == 1));
        chk("dpmem_resp",  dpmem_resp, pmem_resp && (m_owner == 2));
        chk("ipmem_rdata", ipmem_rdata, pmem_rdata);
        chk("dpmem_rdata", dpmem_rdata, pmem_rdata);
        chk("protocol_err", protocol_err, m_perr);
        if (m_owner != 0) chk("pmem_address", pmem_address, m_addr);
        if (m_owner == 2) chk("pmem_wdata", pmem_wdata, m_wdata);
    endtask

    initial begin
        rst_n         = 0;
        ipmem_read    = 0;
        ipmem_address = '0;
        dpmem_read    = 0;
        dpmem_write   = 0;
        dpmem_address = '0;
        dpmem_wdata   = '0;
        pmem_resp     = 0;
        pmem_rdata    = '0;
        i_pend = 0; d_pend = 0; rand_en = 0; mem_en = 0;
        wait_cnt = 0; lat = 0;
        model_reset();

        #3;
        chk("rst_read",    pmem_read, 0);
        chk("rst_write",   pmem_write, 0);
        chk("rst_address", pmem_address, 0);
        chk("rst_wdata",   pmem_wdata, 0);
        chk("rst_perr",    protocol_err, 0);
        #5 rst_n = 1;

        // Simultaneous pair straight after reset: icache must go first.
        @(negedge clk);
        i_pend = 1; ipmem_read = 1; ipmem_address = 32'h0000_0060;
        d_pend = 1; dpmem_read = 1; dpmem_address = 32'h0000_0200;
        mem_en = 1;
        for (int t = 0; t < 4 && m_owner == 0; t++) step();
        chk("simul_first_addr", pmem_address, 32'h0000_0060);
        for (int t = 0; t < 40 && (i_pend || d_pend || m_owner != 0); t++) step();
        if (i_pend || d_pend || m_owner != 0) chk("simul_timeout", 1, 0);

        // Randomized traffic
        rand_en = 1;
        repeat (3000) step();

        // Drain outstanding work
        rand_en = 0;
        i_pend = 0; d_pend = 0;
        for (int t = 0; t < 20 && (m_owner != 0 || m_turn); t++) step();
        if (m_owner != 0 || m_turn) chk("drain_timeout", 1, 0);

        // Async reset in the middle of a dcache writeback
        mem_en      = 0;
        pmem_resp   = 0;
        d_pend      = 1;
        dpmem_read  = 0;
        dpmem_write = 1;
        dpmem_address = 32'h0000_0100;
        dpmem_wdata   = {32{8'hA5}};
        for (int t = 0; t < 6 && m_owner != 2; t++) step();
        if (m_owner != 2) chk("wb_grant_timeout", 1, 0);
        step();
        chk("wb_write_held", pmem_write, 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_write", pmem_write, 0);
        chk("async_rst_read",  pmem_read, 0);
        chk("async_rst_dresp", dpmem_resp, 0);
        chk("async_rst_addr",  pmem_address, 0);
        chk("async_rst_perr",  protocol_err, 0);
        model_reset();
        d_pend = 0; dpmem_write = 0;
        @(posedge clk);
        #2 rst_n = 1;
        mem_en = 1;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port (256-bit line interface) between the instruction cache and the data cache in the mp3 pipelined RV32I core.
- Sits inside mp3, between the icache/dcache pmem-side ports and the top-level pmem_* ports that connect to the memory model.
- Grants one cache at a time and uses alternating priority when both request in the same cycle.
- Latches the address and write data at grant, so the memory sees stable inputs for the whole transaction.

Parameters:
ADDR_W, 32, physical address width
LINE_W, 256, cache line / burst data width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ipmem_read  in  1  icache line-read request, held until ipmem_resp
ipmem_address  in  ADDR_W  icache line address
ipmem_resp  out  1  icache transaction done (1 cycle)
ipmem_rdata  out  LINE_W  icache read data
dpmem_read  in  1  dcache line-read request
dpmem_write  in  1  dcache line-writeback request
dpmem_address  in  ADDR_W  dcache line address
dpmem_wdata  in  LINE_W  dcache writeback data
dpmem_resp  out  1  dcache transaction done (1 cycle)
dpmem_rdata  out  LINE_W  dcache read data
pmem_read  out  1  to memory
pmem_write  out  1  to memory
pmem_address  out  ADDR_W  to memory
pmem_wdata  out  LINE_W  to memory
pmem_resp  in  1  memory done
pmem_rdata  in  LINE_W  memory read data
protocol_err  out  1  sticky: dcache asserted read and write together

Behaviour:
- Reset (rst_n=0, async, takes effect immediately): state=IDLE, last_grant=D, pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, protocol_err=0. Reset mid-transaction abandons the transaction; no resp is issued.
- States:
  - IDLE: no memory command.
  - GNT_I: icache owns the port.
  - GNT_D: dcache owns the port.
  - DONE: one-cycle turnaround.
- IDLE transitions:
  - ireq=ipmem_read; dreq=dpmem_read|dpmem_write.
  - Only ireq -> GNT_I. Only dreq -> GNT_D.
  - Both -> the side that is not last_grant (last_grant=D gives I, and vice versa).
  - Neither -> stay in IDLE.
- On the grant edge, register:
  - address from the winner.
  - wdata from dpmem_wdata (dcache grants only).
  - command: pmem_read=1 for an icache grant or dcache read; pmem_write=1 for a dcache write.
  - last_grant set to the winner.
- Latency: a request first sampled at edge N drives pmem_read/write high after edge N. Commands are registered outputs, held constant until pmem_resp.
- GNT_x transitions:
  - While pmem_resp=0, hold all pmem_* outputs.
  - On a cycle with pmem_resp=1:
    - The granted side's resp is 1 in that same cycle (combinational: ipmem_resp = pmem_resp & (state==GNT_I); likewise for D).
    - At the next edge, clear pmem_read/write and go to DONE.
- DONE: outputs deasserted; go to IDLE unconditionally. This guarantees one idle cycle between back-to-back memory transactions, and lets the cache drop its request after resp before being re-arbitrated.
- Read data: ipmem_rdata = dpmem_rdata = pmem_rdata (unregistered). A cache qualifies it only with its own resp.
- The non-granted side's resp is always 0, even if pmem_resp glitches high outside GNT states.
- Requester drops its request mid-grant: the transaction still completes and resp is still pulsed.
- dcache read and write both high when sampled for grant:
  - The write takes precedence (pmem_write=1, pmem_read=0).
  - protocol_err sets and stays set until reset.
- pmem_read and pmem_write are never asserted together.
- Starvation bound: a waiting requester is granted within one foreign transaction.

Test Plan:
- Icache-only read: ipmem_read=1, ipmem_address=0x00000060, memory resp after 5 cycles -> pmem_read=1 with address 0x60 from the cycle after the request; ipmem_resp pulses exactly 1 cycle with rdata=memory line; dpmem_resp stays 0; one DONE cycle follows.
- Simultaneous requests after reset: ipmem_read=1 and dpmem_read=1 at the same edge (last_grant=D) -> icache served first; dcache granted 2 cycles after ipmem_resp (DONE, then IDLE); a second simultaneous pair afterwards also goes to I first, because last_grant=D again.
- Dcache writeback: dpmem_write=1, address 0x00000100, wdata=0xA5 repeated across the line; change dpmem_wdata one cycle after grant -> pmem_wdata keeps the latched 0xA5 pattern; pmem_write=1 and pmem_read=0 throughout; dpmem_resp pulses once.
- Address stability: during GNT_I, change ipmem_address to 0xDEADBEE0 -> pmem_address unchanged until DONE.
- Async reset mid-transaction: assert rst_n=0 during GNT_D before pmem_resp -> pmem_write drops without waiting for a clock edge; no dpmem_resp; after release with no requests, state stays IDLE.
- Protocol error: dpmem_read=dpmem_write=1 -> write issued, protocol_err=1 and it stays 1 across subsequent clean transactions until reset.
